// File: rtl/traffic_fsm_if.sv
// Traffic controller bus: mode/request inputs and light/debug outputs.
// Clock and reset stay plain ports on the controller.
interface traffic_fsm_if;
  logic       night;
  logic       ped_req;
  logic [1:0] light_a;
  logic [1:0] light_b;
  logic [2:0] phase;
  logic       ped_pend;

  modport master (
    output night,
    output ped_req,
    input  light_a,
    input  light_b,
    input  phase,
    input  ped_pend
  );

  modport slave (
    input  night,
    input  ped_req,
    output light_a,
    output light_b,
    output phase,
    output ped_pend
  );
endinterface

// File: rtl/traffic_fsm.sv
// Two-approach traffic light controller with night flashing mode.
// Pedestrian cut-short is enabled by defining TRAFFIC_PED_EN.
module traffic_fsm #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int T_GREEN       = 20,
  parameter int T_YELLOW      = 3,
  parameter int T_ALLRED      = 1,
  parameter int T_MIN_GREEN   = 5
) (
  input  logic clk,
  input  logic reset,
  traffic_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    GREEN_A  = 3'd1,
    YELLOW_A = 3'd2,
    ALLRED_B = 3'd3,
    GREEN_B  = 3'd4,
    YELLOW_B = 3'd5,
    FLASH    = 3'd6,
    BAD      = 3'd7
  } state_t;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;
  localparam logic [1:0] OFF = 2'b11;

  localparam longint unsigned TPS   = longint'(TICKS_PER_SEC);
  localparam longint unsigned N_GRN = longint'(T_GREEN) * TPS;
  localparam longint unsigned N_YEL = longint'(T_YELLOW) * TPS;
  localparam longint unsigned N_ARD = longint'(T_ALLRED) * TPS;
  localparam longint unsigned N_MIN = longint'(T_MIN_GREEN) * TPS;

  localparam longint unsigned M1 = (N_GRN > N_YEL) ? N_GRN : N_YEL;
  localparam longint unsigned M2 = (M1 > N_ARD) ? M1 : N_ARD;
  localparam longint unsigned NMAX = (M2 > TPS) ? M2 : TPS;
  localparam int CW = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [CW-1:0] L_GRN = CW'(N_GRN - 1);
  localparam logic [CW-1:0] L_YEL = CW'(N_YEL - 1);
  localparam logic [CW-1:0] L_ARD = CW'(N_ARD - 1);
  localparam logic [CW-1:0] L_MIN = CW'(N_MIN - 1);
  localparam logic [CW-1:0] L_SEC = CW'(TPS - 1);

  state_t      st;
  state_t      nst;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic        off;
  logic        noff;
  logic        done;
  logic        cut;
  logic        pend;
  logic [1:0]  la;
  logic [1:0]  lb;
  logic [1:0]  nla;
  logic [1:0]  nlb;

  always_comb begin
    lim = L_SEC;
    unique case (st)
      ALLRED_A, ALLRED_B: lim = L_ARD;
      GREEN_A, GREEN_B:   lim = L_GRN;
      YELLOW_A, YELLOW_B: lim = L_YEL;
      FLASH, BAD:         lim = L_SEC;
    endcase
  end

  assign done = (cnt == lim);

`ifdef TRAFFIC_PED_EN
  // Early exit from green once the minimum green has elapsed.
  assign cut = pend && (cnt >= L_MIN) &&
               ((st == GREEN_A) || (st == GREEN_B));
`else
  assign cut = 1'b0;
`endif

  always_comb begin
    nst  = st;
    noff = off;
    if (st == FLASH) begin
      if (!bus.night)
        nst = ALLRED_A;
      else if (done)
        noff = ~off;
    end else if (bus.night) begin
      nst  = FLASH;
      noff = 1'b0;
    end else begin
      unique case (st)
        ALLRED_A: if (done)        nst = GREEN_A;
        GREEN_A:  if (done || cut) nst = YELLOW_A;
        YELLOW_A: if (done)        nst = ALLRED_B;
        ALLRED_B: if (done)        nst = GREEN_B;
        GREEN_B:  if (done || cut) nst = YELLOW_B;
        YELLOW_B: if (done)        nst = ALLRED_A;
        FLASH:                     nst = ALLRED_A;
        BAD:                       nst = ALLRED_A;
      endcase
    end
  end

  // Lights are decoded from the next state so they change with it.
  always_comb begin
    nla = RED;
    nlb = RED;
    unique case (nst)
      GREEN_A:  nla = GRN;
      YELLOW_A: nla = YEL;
      GREEN_B:  nlb = GRN;
      YELLOW_B: nlb = YEL;
      FLASH: begin
        nla = noff ? OFF : YEL;
        nlb = noff ? OFF : YEL;
      end
      ALLRED_A, ALLRED_B, BAD: begin
        nla = RED;
        nlb = RED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= ALLRED_A;
      cnt <= '0;
      off <= 1'b0;
      la  <= RED;
      lb  <= RED;
    end else begin
      st  <= nst;
      off <= noff;
      la  <= nla;
      lb  <= nlb;
      if ((nst != st) || (st == FLASH && done))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

`ifdef TRAFFIC_PED_EN
  logic clr;

  // Only the normal yellow->all-red step serves a request; leaving FLASH
  // keeps it so the cut-short applies to the next green.
  assign clr = ((st == YELLOW_A) && (nst == ALLRED_B)) ||
               ((st == YELLOW_B) && (nst == ALLRED_A));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pend <= 1'b0;
    else
      pend <= bus.ped_req | (pend & ~clr);
  end
`else
  assign pend = 1'b0;
`endif

  assign bus.phase    = st;
  assign bus.light_a  = la;
  assign bus.light_b  = lb;
  assign bus.ped_pend = pend;

endmodule
